// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with write-first bypass and per-register busy scoreboard
module regfile_scoreboard #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int A0_INDEX      = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDRESS_WIDTH-1:0] AD1,
    input  logic [ADDRESS_WIDTH-1:0] AD2,
    output logic [DATA_WIDTH-1:0]    RD1,
    output logic [DATA_WIDTH-1:0]    RD2,
    output logic                     STALL1,
    output logic                     STALL2,
    input  logic                     issue_valid,
    input  logic [ADDRESS_WIDTH-1:0] issue_rd,
    output logic                     issue_ready,
    input  logic                     WE3,
    input  logic [ADDRESS_WIDTH-1:0] AD3,
    input  logic [DATA_WIDTH-1:0]    WD3,
    output logic [DATA_WIDTH-1:0]    a0
);
    localparam int DEPTH = 2**ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] A0_ADDR = ADDRESS_WIDTH'(A0_INDEX);

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]      busy_q, busy_d;
    logic                  wr_en, issue_acc;

    assign wr_en     = WE3 && AD3 != '0;
    assign issue_acc = issue_valid && issue_ready && issue_rd != '0;

    // Reads are forced to zero during reset and for index 0, otherwise the pending write wins
    assign RD1 = (!rst_n || AD1 == '0) ? '0 : (wr_en && AD3 == AD1) ? WD3 : regs_q[AD1];
    assign RD2 = (!rst_n || AD2 == '0) ? '0 : (wr_en && AD3 == AD2) ? WD3 : regs_q[AD2];
    assign a0  = (!rst_n || A0_ADDR == '0) ? '0 : (wr_en && AD3 == A0_ADDR) ? WD3 : regs_q[A0_ADDR];

    // A same-cycle writeback to a busy source resolves its hazard through the bypass
    assign STALL1      = rst_n && busy_q[AD1] && !(WE3 && AD3 == AD1);
    assign STALL2      = rst_n && busy_q[AD2] && !(WE3 && AD3 == AD2);
    assign issue_ready = !rst_n || !busy_q[issue_rd] || (WE3 && AD3 == issue_rd);

    // Next busy vector: writeback clears, an accepted issue sets and wins on the same index
    always_comb begin
        busy_d = busy_q;
        if (WE3) busy_d[AD3] = 1'b0;
        if (issue_acc) busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Data storage; index 0 is never written so it stays zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[AD3] <= WD3;
        end
    end

    // Busy bits, cleared asynchronously so reset drops every pending reservation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed scenarios plus random stream against an array-based model
module tb_regfile_scoreboard;
    logic        clk, rst_n;
    logic [4:0]  ad1, ad2, ird, ad3;
    logic [31:0] wd3;
    logic        we3, iv;

    logic [31:0] rd1_a, rd2_a, a0_a;
    logic        st1_a, st2_a, rdy_a;
    logic [15:0] rd1_b, rd2_b, a0_b;
    logic        st1_b, st2_b, rdy_b;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem_a [32];
    logic        busy_a [32];
    logic [15:0] mem_b [8];
    logic        busy_b [8];

    regfile_scoreboard #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .A0_INDEX(10)) dut_a (
        .clk(clk), .rst_n(rst_n), .AD1(ad1), .AD2(ad2), .RD1(rd1_a), .RD2(rd2_a),
        .STALL1(st1_a), .STALL2(st2_a), .issue_valid(iv), .issue_rd(ird), .issue_ready(rdy_a),
        .WE3(we3), .AD3(ad3), .WD3(wd3), .a0(a0_a));

    regfile_scoreboard #(.ADDRESS_WIDTH(3), .DATA_WIDTH(16), .A0_INDEX(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .AD1(ad1[2:0]), .AD2(ad2[2:0]), .RD1(rd1_b), .RD2(rd2_b),
        .STALL1(st1_b), .STALL2(st2_b), .issue_valid(iv), .issue_rd(ird[2:0]), .issue_ready(rdy_b),
        .WE3(we3), .AD3(ad3[2:0]), .WD3(wd3[15:0]), .a0(a0_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ea_rd(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : (we3 && ad3 == a) ? wd3 : mem_a[a];
    endfunction
    function automatic logic ea_st(input logic [4:0] a);
        return a != 5'd0 && busy_a[a] && !(we3 && ad3 == a);
    endfunction
    function automatic logic ea_rdy(input logic [4:0] a);
        return a == 5'd0 || !busy_a[a] || (we3 && ad3 == a);
    endfunction
    function automatic logic [15:0] eb_rd(input logic [2:0] a);
        return (a == 3'd0) ? 16'd0 : (we3 && ad3[2:0] == a) ? wd3[15:0] : mem_b[a];
    endfunction
    function automatic logic eb_st(input logic [2:0] a);
        return a != 3'd0 && busy_b[a] && !(we3 && ad3[2:0] == a);
    endfunction
    function automatic logic eb_rdy(input logic [2:0] a);
        return a == 3'd0 || !busy_b[a] || (we3 && ad3[2:0] == a);
    endfunction

    task automatic idle();
        we3 = 1'b0; iv = 1'b0; ad1 = '0; ad2 = '0; ad3 = '0; ird = '0; wd3 = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        we3 = 1'b1; ad3 = 5'd5; wd3 = 32'hDEADBEEF; ad1 = 5'd5; ad2 = 5'd10;
        iv = 1'b1; ird = 5'd7;
        #2;
        n_cmp++; if (rd1_a !== 32'd0) begin n_err++; $display("FAIL reset_rd1 got %h want 0", rd1_a); end
        n_cmp++; if (a0_a !== 32'd0) begin n_err++; $display("FAIL reset_a0 got %h want 0", a0_a); end
        n_cmp++; if (rdy_a !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", rdy_a); end
        tick(); tick();
        ad1 = 5'd7;
        #1;
        n_cmp++; if (st1_a !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", st1_a); end
        idle();
        rst_n = 1'b1;
        ad1 = 5'd7; ad2 = 5'd5;
        #1;
        n_cmp++; if (st1_a !== 1'b0) begin n_err++; $display("FAIL reset_nobusy got %b want 0", st1_a); end
        n_cmp++; if (rd2_a !== 32'd0) begin n_err++; $display("FAIL reset_nowrite got %h want 0", rd2_a); end
        tick();
    endtask

    task automatic test_bypass();
        idle();
        we3 = 1'b1; ad3 = 5'd5; wd3 = 32'hDEADBEEF; ad1 = 5'd5;
        #1;
        n_cmp++; if (rd1_a !== 32'hDEADBEEF) begin n_err++; $display("FAIL bypass_same got %h want deadbeef", rd1_a); end
        tick();
        we3 = 1'b0;
        #1;
        n_cmp++; if (rd1_a !== 32'hDEADBEEF) begin n_err++; $display("FAIL bypass_stored got %h want deadbeef", rd1_a); end
    endtask

    task automatic test_zero();
        idle();
        we3 = 1'b1; ad3 = 5'd0; wd3 = 32'hFFFFFFFF; ad1 = 5'd0;
        #1;
        n_cmp++; if (rd1_a !== 32'd0) begin n_err++; $display("FAIL zero_bypass got %h want 0", rd1_a); end
        tick();
        we3 = 1'b0; iv = 1'b1; ird = 5'd0;
        #1;
        n_cmp++; if (rdy_a !== 1'b1) begin n_err++; $display("FAIL zero_ready got %b want 1", rdy_a); end
        tick();
        iv = 1'b0;
        #1;
        n_cmp++; if (rd1_a !== 32'd0) begin n_err++; $display("FAIL zero_read got %h want 0", rd1_a); end
        n_cmp++; if (st1_a !== 1'b0) begin n_err++; $display("FAIL zero_stall got %b want 0", st1_a); end
    endtask

    task automatic test_issue_wb();
        idle();
        iv = 1'b1; ird = 5'd7;
        #1;
        n_cmp++; if (rdy_a !== 1'b1) begin n_err++; $display("FAIL iss_ready0 got %b want 1", rdy_a); end
        tick();
        iv = 1'b0; ad2 = 5'd7;
        #1;
        n_cmp++; if (st2_a !== 1'b1) begin n_err++; $display("FAIL iss_stall got %b want 1", st2_a); end
        n_cmp++; if (rdy_a !== 1'b0) begin n_err++; $display("FAIL iss_busy_ready got %b want 0", rdy_a); end
        we3 = 1'b1; ad3 = 5'd7; wd3 = 32'h12;
        #1;
        n_cmp++; if (st2_a !== 1'b0) begin n_err++; $display("FAIL wb_stall got %b want 0", st2_a); end
        n_cmp++; if (rd2_a !== 32'h12) begin n_err++; $display("FAIL wb_rd2 got %h want 12", rd2_a); end
        tick();
        we3 = 1'b0;
        #1;
        n_cmp++; if (st2_a !== 1'b0) begin n_err++; $display("FAIL wb_cleared got %b want 0", st2_a); end
        n_cmp++; if (rdy_a !== 1'b1) begin n_err++; $display("FAIL wb_ready got %b want 1", rdy_a); end
    endtask

    task automatic test_issue_wins();
        idle();
        iv = 1'b1; ird = 5'd9;
        tick();
        iv = 1'b0; ad1 = 5'd9;
        #1;
        n_cmp++; if (st1_a !== 1'b1) begin n_err++; $display("FAIL win_busy got %b want 1", st1_a); end
        we3 = 1'b1; ad3 = 5'd9; wd3 = 32'h99; iv = 1'b1;
        #1;
        n_cmp++; if (rdy_a !== 1'b1) begin n_err++; $display("FAIL win_ready got %b want 1", rdy_a); end
        tick();
        we3 = 1'b0; iv = 1'b0;
        #1;
        n_cmp++; if (st1_a !== 1'b1) begin n_err++; $display("FAIL win_still_busy got %b want 1", st1_a); end
        n_cmp++; if (rd1_a !== 32'h99) begin n_err++; $display("FAIL win_data got %h want 99", rd1_a); end
        we3 = 1'b1; ad3 = 5'd9; wd3 = 32'h99;
        tick();
    endtask

    task automatic test_a0_reset();
        idle();
        iv = 1'b1; ird = 5'd3;
        tick();
        iv = 1'b0; we3 = 1'b1; ad3 = 5'd10; wd3 = 32'hA5; ad1 = 5'd3; ad2 = 5'd10;
        #1;
        n_cmp++; if (a0_a !== 32'hA5) begin n_err++; $display("FAIL a0_bypass got %h want a5", a0_a); end
        n_cmp++; if (st1_a !== 1'b1) begin n_err++; $display("FAIL a0_pre_stall got %b want 1", st1_a); end
        tick();
        we3 = 1'b0;
        #1;
        n_cmp++; if (a0_a !== 32'hA5) begin n_err++; $display("FAIL a0_stored got %h want a5", a0_a); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (a0_a !== 32'd0) begin n_err++; $display("FAIL a0_async got %h want 0", a0_a); end
        n_cmp++; if (st1_a !== 1'b0) begin n_err++; $display("FAIL async_stall got %b want 0", st1_a); end
        n_cmp++; if (rd2_a !== 32'd0) begin n_err++; $display("FAIL async_rd2 got %h want 0", rd2_a); end
        tick();
        rst_n = 1'b1;
        #1;
        n_cmp++; if (st1_a !== 1'b0) begin n_err++; $display("FAIL post_rst_stall got %b want 0", st1_a); end
        n_cmp++; if (a0_a !== 32'd0) begin n_err++; $display("FAIL post_rst_a0 got %h want 0", a0_a); end
    endtask

    task automatic test_random();
        logic acc_a, acc_b;
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin mem_a[i] = '0; busy_a[i] = 1'b0; end
        for (int i = 0; i < 8; i++) begin mem_b[i] = '0; busy_b[i] = 1'b0; end
        for (int c = 0; c < 600; c++) begin
            we3 = 1'($urandom % 2);
            ad3 = 5'($urandom);
            wd3 = $urandom;
            iv  = 1'($urandom % 2);
            ird = 5'($urandom);
            ad1 = ($urandom % 4 == 0) ? ad3 : 5'($urandom);
            ad2 = ($urandom % 4 == 0) ? ird : 5'($urandom);
            #2;
            n_cmp++; if (rd1_a !== ea_rd(ad1)) begin n_err++; $display("FAIL rnd_a_rd1 cyc %0d got %h want %h", c, rd1_a, ea_rd(ad1)); end
            n_cmp++; if (rd2_a !== ea_rd(ad2)) begin n_err++; $display("FAIL rnd_a_rd2 cyc %0d got %h want %h", c, rd2_a, ea_rd(ad2)); end
            n_cmp++; if (st1_a !== ea_st(ad1)) begin n_err++; $display("FAIL rnd_a_st1 cyc %0d got %b want %b", c, st1_a, ea_st(ad1)); end
            n_cmp++; if (st2_a !== ea_st(ad2)) begin n_err++; $display("FAIL rnd_a_st2 cyc %0d got %b want %b", c, st2_a, ea_st(ad2)); end
            n_cmp++; if (rdy_a !== ea_rdy(ird)) begin n_err++; $display("FAIL rnd_a_rdy cyc %0d got %b want %b", c, rdy_a, ea_rdy(ird)); end
            n_cmp++; if (a0_a !== ea_rd(5'd10)) begin n_err++; $display("FAIL rnd_a_a0 cyc %0d got %h want %h", c, a0_a, ea_rd(5'd10)); end
            n_cmp++; if (rd1_b !== eb_rd(ad1[2:0])) begin n_err++; $display("FAIL rnd_b_rd1 cyc %0d got %h want %h", c, rd1_b, eb_rd(ad1[2:0])); end
            n_cmp++; if (rd2_b !== eb_rd(ad2[2:0])) begin n_err++; $display("FAIL rnd_b_rd2 cyc %0d got %h want %h", c, rd2_b, eb_rd(ad2[2:0])); end
            n_cmp++; if (st1_b !== eb_st(ad1[2:0])) begin n_err++; $display("FAIL rnd_b_st1 cyc %0d got %b want %b", c, st1_b, eb_st(ad1[2:0])); end
            n_cmp++; if (st2_b !== eb_st(ad2[2:0])) begin n_err++; $display("FAIL rnd_b_st2 cyc %0d got %b want %b", c, st2_b, eb_st(ad2[2:0])); end
            n_cmp++; if (rdy_b !== eb_rdy(ird[2:0])) begin n_err++; $display("FAIL rnd_b_rdy cyc %0d got %b want %b", c, rdy_b, eb_rdy(ird[2:0])); end
            n_cmp++; if (a0_b !== eb_rd(3'd5)) begin n_err++; $display("FAIL rnd_b_a0 cyc %0d got %h want %h", c, a0_b, eb_rd(3'd5)); end
            acc_a = iv && ea_rdy(ird) && ird != 5'd0;
            acc_b = iv && eb_rdy(ird[2:0]) && ird[2:0] != 3'd0;
            tick();
            if (we3 && ad3 != 5'd0) mem_a[ad3] = wd3;
            if (we3) busy_a[ad3] = 1'b0;
            if (acc_a) busy_a[ird] = 1'b1;
            if (we3 && ad3[2:0] != 3'd0) mem_b[ad3[2:0]] = wd3[15:0];
            if (we3) busy_b[ad3[2:0]] = 1'b0;
            if (acc_b) busy_b[ird[2:0]] = 1'b1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_bypass();
        test_zero();
        test_issue_wb();
        test_issue_wins();
        test_a0_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 5, SHALL set register index width; depth = 2**ADDRESS_WIDTH entries.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set register data width.
REQ-003 Parameter A0_INDEX, default 10, SHALL set which register drives the a0 debug output.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 AD1, AD2  input  ADDRESS_WIDTH  read-port source indices.
REQ-007 RD1, RD2  output  DATA_WIDTH  read-port data.
REQ-008 STALL1, STALL2  output  1  high when the corresponding source has a pending, unforwardable write.
REQ-009 issue_valid  input  1  request to reserve destination issue_rd.
REQ-010 issue_rd  input  ADDRESS_WIDTH  destination index being reserved.
REQ-011 issue_ready  output  1  high when an issue request can be accepted this cycle.
REQ-012 WE3  input  1  writeback enable.
REQ-013 AD3  input  ADDRESS_WIDTH  writeback index.
REQ-014 WD3  input  DATA_WIDTH  writeback data.
REQ-015 a0  output  DATA_WIDTH  current contents of register A0_INDEX, including same-cycle bypass.

Function
REQ-016 Storage SHALL be 2**ADDRESS_WIDTH x DATA_WIDTH registers plus one busy bit per register.
REQ-017 Register 0 SHALL always read as 0; writes to index 0 SHALL be ignored; busy[0] SHALL never set.
REQ-018 Reads SHALL be combinational, with zero-cycle latency from AD1/AD2.
REQ-019 Write-first bypass: if WE3=1, AD3=ADn and ADn!=0, RDn SHALL equal WD3 in the same cycle.
REQ-020 A write SHALL commit at the rising edge when WE3=1 and AD3!=0; the stored value is visible without bypass from the next cycle.
REQ-021 STALLn SHALL equal busy[ADn] AND NOT (WE3=1 AND AD3=ADn); it SHALL be 0 for ADn=0.
REQ-022 issue_ready SHALL equal NOT busy[issue_rd] OR (WE3=1 AND AD3=issue_rd); it SHALL be 1 for issue_rd=0.
REQ-023 An issue is accepted when issue_valid=1 and issue_ready=1; busy[issue_rd] SHALL be set at that edge unless issue_rd=0.
REQ-024 A writeback with WE3=1 SHALL clear busy[AD3] at the edge, unless the same edge accepts an issue to the same index, in which case busy SHALL remain 1 (issue wins).
REQ-025 A writeback to a non-busy register SHALL still commit data and leave busy at 0.
REQ-026 Issue and writeback to different indices in the same cycle SHALL update independently.
REQ-027 Rejected issues (issue_ready=0) SHALL leave all state unchanged.
REQ-028 All outputs SHALL be free of X after reset for any in-range inputs.

Reset
REQ-029 On rst_n=0, all data registers SHALL clear to 0 and all busy bits SHALL clear asynchronously, without waiting for clk.
REQ-030 During reset, RD1, RD2 and a0 SHALL read 0 (bypass suppressed), STALL1/STALL2 SHALL be 0, and issue_ready SHALL be 1.
REQ-031 Reset asserted mid-operation SHALL discard all pending reservations; the first edge after rst_n rises SHALL behave as a fresh start.

Verification
REQ-032 Reset, then WE3=1 AD3=5 WD3=0xDEADBEEF with AD1=5 -> RD1=0xDEADBEEF in the same cycle; next cycle with WE3=0 -> RD1=0xDEADBEEF.
REQ-033 Write AD3=0 WD3=0xFFFFFFFF, then read AD1=0 -> RD1=0; issue_rd=0 -> busy never set and STALL1=0.
REQ-034 Issue rd=7 accepted; next cycle AD2=7 -> STALL2=1 and issue_ready(rd=7)=0; writeback AD3=7 WD3=0x12 -> STALL2=0 and RD2=0x12 in that cycle, busy[7]=0 after the edge.
REQ-035 busy[9]=1, same cycle WE3=1 AD3=9 plus issue_valid=1 issue_rd=9 -> issue_ready=1, data committed, busy[9] still 1 after the edge.
REQ-036 Write AD3=10 WD3=0xA5 -> a0=0xA5 combinationally; assert rst_n=0 between edges -> a0=0 and all STALL=0 immediately.
REQ-037 Random issue/writeback/read stream checked against a reference model for RD, STALL and issue_ready at ADDRESS_WIDTH=5 and ADDRESS_WIDTH=3, DATA_WIDTH=32 and DATA_WIDTH=16.
